// File: rtl/psum_op_dispatcher_pkg.sv
// Shared types and widths for the psum op dispatcher.
//   op_desc_t    : descriptor {seq1, seq2, id} carried through the FIFO
//   disp_state_t : issue FSM states
//   desc_is_bad  : a descriptor with a zero seq1 or seq2 is rejected at the input
package psum_op_dispatcher_pkg;

  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned OP_ID_WIDTH = 8;
  localparam int unsigned SEQ2_WIDTH  = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  seq1;
    logic [SEQ2_WIDTH-1:0]  seq2;
    logic [OP_ID_WIDTH-1:0] id;
  } op_desc_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAssign
  } disp_state_t;

  function automatic logic desc_is_bad(op_desc_t d);
    return (d.seq1 == '0) || (d.seq2 == '0);
  endfunction

endpackage

// File: rtl/psum_op_dispatcher_fifo.sv
// Synchronous descriptor FIFO, first-word-fall-through head.
//   clk, reset       : clock, asynchronous active-high reset
//   i_push, i_data   : write request and descriptor (ignored when full)
//   i_pop            : read request (ignored when empty)
//   o_head           : descriptor at the head, valid while !o_empty
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored descriptors
module psum_op_dispatcher_fifo
  import psum_op_dispatcher_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  op_desc_t                   i_data,
  input  logic                       i_pop,
  output op_desc_t                   o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(Depth):0]     o_count
);

  localparam int unsigned PtrW = $clog2(Depth);

  op_desc_t          r_mem [Depth];
  logic [PtrW:0]     r_wptr;
  logic [PtrW:0]     r_rptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wptr - r_rptr;
  assign o_full    = (o_count == (PtrW + 1)'(Depth));
  assign o_empty   = (r_wptr == r_rptr);
  assign o_head    = r_mem[r_rptr[PtrW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[PtrW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/psum_op_dispatcher.sv
// Psum op dispatcher: buffers descriptors from the controller and issues them one at
// a time to psum_manager as single-cycle new_op_request pulses, tracking assigned ops
// in an in-flight id table until op_done retires them.
//   clk, reset                     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_*         : descriptor input handshake
//   new_op_request, seq1, seq2,
//   operation_id                   : issue pulse and held descriptor fields
//   assign_valid, stall            : psum_manager grant and back-pressure
//   op_done, op_done_id            : completion pulse and id
//   queue_count, outstanding_cnt,
//   idle                           : status
//   err_bad_desc, err_unknown_done,
//   err_timeout                    : single-cycle error pulses
// Optional feature: define DISPATCH_WATCHDOG_EN to drop an op whose assign_valid does
// not arrive within WDOG_CYCLES; otherwise WAIT_ASSIGN waits forever.
module psum_op_dispatcher
  import psum_op_dispatcher_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WDOG_CYCLES     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_seq1,
  input  logic [SEQ2_WIDTH-1:0]         in_seq2,
  input  logic [OP_ID_WIDTH-1:0]        in_op_id,
  output logic                          new_op_request,
  output logic [ADDR_WIDTH-1:0]         seq1,
  output logic [SEQ2_WIDTH-1:0]         seq2,
  output logic [OP_ID_WIDTH-1:0]        operation_id,
  input  logic                          assign_valid,
  input  logic                          stall,
  input  logic                          op_done,
  input  logic [OP_ID_WIDTH-1:0]        op_done_id,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic [3:0]                    outstanding_cnt,
  output logic                          idle,
  output logic                          err_bad_desc,
  output logic                          err_unknown_done,
  output logic                          err_timeout
);

  localparam int unsigned SlotW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [3:0]  MaxOut = 4'(MAX_OUTSTANDING);

  disp_state_t                r_state;
  logic                       r_new_op;
  logic [ADDR_WIDTH-1:0]      r_seq1;
  logic [SEQ2_WIDTH-1:0]      r_seq2;
  logic [OP_ID_WIDTH-1:0]     r_op_id;
  logic [MAX_OUTSTANDING-1:0] r_slot_valid;
  logic [OP_ID_WIDTH-1:0]     r_slot_id [MAX_OUTSTANDING];
  logic [3:0]                 r_outstanding;
  logic                       r_err_bad;
  logic                       r_err_unknown;

  op_desc_t                   w_in_desc;
  op_desc_t                   w_head;
  logic                       w_in_fire;
  logic                       w_in_bad;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_can_issue;
  logic                       w_assign;
  logic                       w_done_hit;
  logic                       w_match;
  logic [SlotW-1:0]           w_match_idx;
  logic [SlotW-1:0]           w_free_idx;

  assign w_in_desc = '{seq1: in_seq1, seq2: in_seq2, id: in_op_id};
  assign w_in_fire = in_valid && in_ready;
  assign w_in_bad  = desc_is_bad(w_in_desc);
  assign w_push    = w_in_fire && !w_in_bad;
  assign in_ready  = !w_full;

  psum_op_dispatcher_fifo #(
    .Depth (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_in_desc),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (queue_count)
  );

  // The head is captured into the output registers on the same edge it is popped.
  assign w_can_issue = (r_state == StIdle) && !w_empty && !stall && (r_outstanding < MaxOut);
  assign w_pop       = w_can_issue;
  assign w_assign    = (r_state == StWaitAssign) && assign_valid;
  assign w_done_hit  = op_done && w_match;

  // Descending scan so the lowest-index slot wins for both searches. Lookup uses the
  // current table, so a done can never retire the op being assigned this cycle.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free_idx  = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_slot_valid[i]) begin
        w_free_idx = SlotW'(i);
      end
      if (r_slot_valid[i] && (r_slot_id[i] == op_done_id)) begin
        w_match     = 1'b1;
        w_match_idx = SlotW'(i);
      end
    end
  end

  // In-flight table. A free slot always exists on assign: issue requires
  // outstanding < MAX_OUTSTANDING and only one op can be awaiting assignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_valid  <= '0;
      r_outstanding <= '0;
      r_err_bad     <= 1'b0;
      r_err_unknown <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_slot_id[i] <= '0;
      end
    end else begin
      r_err_bad     <= w_in_fire && w_in_bad;
      r_err_unknown <= op_done && !w_match;
      if (w_done_hit) begin
        r_slot_valid[w_match_idx] <= 1'b0;
      end
      if (w_assign) begin
        r_slot_valid[w_free_idx] <= 1'b1;
        r_slot_id[w_free_idx]    <= r_op_id;
      end
      unique case ({w_assign, w_done_hit})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

`ifdef DISPATCH_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  logic [WdogW-1:0] r_wdog;
  logic             r_err_timeout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_new_op <= 1'b0;
      r_seq1   <= '0;
      r_seq2   <= '0;
      r_op_id  <= '0;
`ifdef DISPATCH_WATCHDOG_EN
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_new_op <= 1'b0;
`ifdef DISPATCH_WATCHDOG_EN
      r_err_timeout <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_can_issue) begin
            r_new_op <= 1'b1;
            r_seq1   <= w_head.seq1;
            r_seq2   <= w_head.seq2;
            r_op_id  <= w_head.id;
            r_state  <= StIssue;
          end
        end
        // Pulse is already on the output; stall here has no effect.
        StIssue: begin
          r_state <= StWaitAssign;
`ifdef DISPATCH_WATCHDOG_EN
          r_wdog  <= '0;
`endif
        end
        StWaitAssign: begin
          if (assign_valid) begin
            r_state <= StIdle;
`ifdef DISPATCH_WATCHDOG_EN
          end else if (r_wdog == WdogW'(WDOG_CYCLES - 1)) begin
            // Op is dropped: it never enters the in-flight table.
            r_err_timeout <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_wdog <= r_wdog + 1'b1;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign new_op_request   = r_new_op;
  assign seq1             = r_seq1;
  assign seq2             = r_seq2;
  assign operation_id     = r_op_id;
  assign outstanding_cnt  = r_outstanding;
  assign idle             = w_empty && (r_state == StIdle) && (r_outstanding == 4'd0);
  assign err_bad_desc     = r_err_bad;
  assign err_unknown_done = r_err_unknown;
`ifdef DISPATCH_WATCHDOG_EN
  assign err_timeout      = r_err_timeout;
`else
  assign err_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_psum_op_dispatcher.sv
module tb_psum_op_dispatcher;

  localparam int unsigned QD = 4;
  localparam int unsigned MO = 4;
  localparam int unsigned WD = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_seq1 = '0;
  logic [15:0] in_seq2 = '0;
  logic [7:0]  in_op_id = '0;
  logic        new_op_request;
  logic [7:0]  seq1;
  logic [15:0] seq2;
  logic [7:0]  operation_id;
  logic        assign_valid = 1'b0;
  logic        stall = 1'b0;
  logic        op_done = 1'b0;
  logic [7:0]  op_done_id = '0;
  logic [2:0]  queue_count;
  logic [3:0]  outstanding_cnt;
  logic        idle;
  logic        err_bad_desc;
  logic        err_unknown_done;
  logic        err_timeout;

  always #5 clk = ~clk;

  psum_op_dispatcher #(
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MO),
    .WDOG_CYCLES     (WD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_seq1          (in_seq1),
    .in_seq2          (in_seq2),
    .in_op_id         (in_op_id),
    .new_op_request   (new_op_request),
    .seq1             (seq1),
    .seq2             (seq2),
    .operation_id     (operation_id),
    .assign_valid     (assign_valid),
    .stall            (stall),
    .op_done          (op_done),
    .op_done_id       (op_done_id),
    .queue_count      (queue_count),
    .outstanding_cnt  (outstanding_cnt),
    .idle             (idle),
    .err_bad_desc     (err_bad_desc),
    .err_unknown_done (err_unknown_done),
    .err_timeout      (err_timeout)
  );

  typedef struct {
    logic [7:0]  s1;
    logic [15:0] s2;
    logic [7:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   req_cnt = 0;
  int   bad_cnt = 0;
  int   unk_cnt = 0;
  int   to_cnt = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   to_cyc = 0;
  bit   auto_assign = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every issue pulse and counts error pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (new_op_request) begin
          req_cnt++;
          req_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected actual_id=%0h required=none", operation_id);
          end else begin
            e = exp_q.pop_front();
            chk("req_seq1", {24'h0, seq1}, {24'h0, e.s1});
            chk("req_seq2", {16'h0, seq2}, {16'h0, e.s2});
            chk("req_id", {24'h0, operation_id}, {24'h0, e.id});
          end
        end
        if (err_bad_desc)     bad_cnt++;
        if (err_unknown_done) unk_cnt++;
        if (err_timeout) begin
          to_cnt++;
          to_cyc = cyc;
        end
      end
    end
  end

  // psum_manager stub: grants a bank two cycles after each issue pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && new_op_request && auto_assign) begin
        @(posedge clk);
        @(posedge clk);
        #1 assign_valid = 1'b1;
        @(posedge clk);
        #1 assign_valid = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge after the handshake edge.
  task automatic push(input logic [7:0] s1, input logic [15:0] s2, input logic [7:0] id,
                      input bit expect_issue);
    exp_t e;
    int   budget;
    if (expect_issue) begin
      e.s1 = s1;
      e.s2 = s2;
      e.id = id;
      exp_q.push_back(e);
    end
    in_valid = 1'b1;
    in_seq1  = s1;
    in_seq2  = s2;
    in_op_id = id;
    budget   = 200;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=in_ready_low required=accept id=%0h", id);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic done(input logic [7:0] id);
    op_done    = 1'b1;
    op_done_id = id;
    @(negedge clk);
    op_done    = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    int b;
    b = budget;
    while (outstanding_cnt != 4'(n) && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk(nm, {28'h0, outstanding_cnt}, n);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, {31'h0, in_ready}, 1);
    chk({nm, "_idle"}, {31'h0, idle}, 1);
    chk({nm, "_outs"}, {new_op_request, err_bad_desc, err_unknown_done, err_timeout,
                        queue_count, outstanding_cnt}, 0);
    chk({nm, "_fields"}, {seq1, seq2, operation_id}, 0);
  endtask

  initial begin
    int base;
    int ubase;
    int bbase;
    int b;

    // Reset state, checked while reset is held and after release.
    tick(3);
    chk_reset_vals("rst_held");
    reset = 1'b0;
    tick(2);
    chk_reset_vals("rst_rel");

    // T1: single op issue, assign, retire.
    base = req_cnt;
    push(8'd8, 16'd3, 8'h01, 1'b1);
    wait_out(1, 30, "t1_out1");
    chk("t1_req", req_cnt - base, 1);
    chk("t1_idle_busy", {31'h0, idle}, 0);
    done(8'h01);
    chk("t1_out0", {28'h0, outstanding_cnt}, 0);
    chk("t1_idle", {31'h0, idle}, 1);

    // T2: stall holds issue; release issues in FIFO order.
    stall = 1'b1;
    base  = req_cnt;
    push(8'h11, 16'h0111, 8'h10, 1'b1);
    push(8'h12, 16'h0222, 8'h11, 1'b1);
    tick(10);
    chk("t2_stalled_req", req_cnt - base, 0);
    chk("t2_qcount", {29'h0, queue_count}, 2);
    stall = 1'b0;
    wait_out(2, 40, "t2_out2");
    chk("t2_req", req_cnt - base, 2);
    done(8'h10);
    done(8'h11);
    chk("t2_out0", {28'h0, outstanding_cnt}, 0);

    // T3: in-flight cap.
    base = req_cnt;
    for (int i = 1; i <= 6; i++) begin
      push(8'(8'h40 + i), 16'(i * 3), 8'(i), 1'b1);
    end
    tick(30);
    chk("t3_req_cap", req_cnt - base, 4);
    chk("t3_out_cap", {28'h0, outstanding_cnt}, 4);
    chk("t3_qcount", {29'h0, queue_count}, 2);
    done(8'h02);
    tick(12);
    chk("t3_req_5th", req_cnt - base, 5);
    chk("t3_out_5th", {28'h0, outstanding_cnt}, 4);
    done(8'h01);
    wait_out(4, 30, "t3_out_6th");
    chk("t3_req_6th", req_cnt - base, 6);
    done(8'h03);
    done(8'h04);
    done(8'h05);
    done(8'h06);
    chk("t3_out0", {28'h0, outstanding_cnt}, 0);

    // T4: full FIFO back-pressure, held descriptor not lost.
    stall = 1'b1;
    base  = req_cnt;
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h20 + i), 16'(16'h0100 + i), 8'(8'h20 + i), 1'b1);
    end
    chk("t4_full_ready", {31'h0, in_ready}, 0);
    chk("t4_full_count", {29'h0, queue_count}, 4);
    fork
      push(8'h24, 16'h0104, 8'h24, 1'b1);
      begin
        tick(6);
        chk("t4_held_ready", {31'h0, in_ready}, 0);
        chk("t4_held_count", {29'h0, queue_count}, 4);
        chk("t4_held_req", req_cnt - base, 0);
        stall = 1'b0;
      end
    join
    wait_out(4, 60, "t4_out4");
    done(8'h20);
    wait_out(4, 30, "t4_out4b");
    chk("t4_req", req_cnt - base, 5);
    for (int i = 1; i <= 4; i++) begin
      done(8'(8'h20 + i));
    end
    chk("t4_out0", {28'h0, outstanding_cnt}, 0);
    chk("t4_qcount0", {29'h0, queue_count}, 0);

    // T5: unknown done and bad descriptors.
    base  = req_cnt;
    ubase = unk_cnt;
    bbase = bad_cnt;
    done(8'h55);
    tick(2);
    chk("t5_unknown", unk_cnt - ubase, 1);
    chk("t5_unknown_out", {28'h0, outstanding_cnt}, 0);
    push(8'h05, 16'h0000, 8'h56, 1'b0);
    tick(2);
    chk("t5_bad_seq2", bad_cnt - bbase, 1);
    push(8'h00, 16'h0005, 8'h57, 1'b0);
    tick(2);
    chk("t5_bad_seq1", bad_cnt - bbase, 2);
    chk("t5_bad_qcount", {29'h0, queue_count}, 0);
    tick(4);
    chk("t5_bad_req", req_cnt - base, 0);

`ifdef DISPATCH_WATCHDOG_EN
    // T6: watchdog drops an unassigned op and the next op still issues.
    auto_assign = 1'b0;
    base = to_cnt;
    push(8'h61, 16'h0061, 8'h61, 1'b1);
    b = WD + 40;
    while (to_cnt == base && b > 0) begin
      tick(1);
      b--;
    end
    chk("t6_timeout", to_cnt - base, 1);
    chk("t6_latency", to_cyc - req_cyc, WD + 1);
    chk("t6_out0", {28'h0, outstanding_cnt}, 0);
    auto_assign = 1'b1;
    push(8'h62, 16'h0062, 8'h62, 1'b1);
    wait_out(1, 30, "t6_next");
    done(8'h62);
    chk("t6_out_end", {28'h0, outstanding_cnt}, 0);
`endif

    // T7: reset in WAIT_ASSIGN with one op in flight and one queued.
    auto_assign = 1'b1;
    push(8'h71, 16'h0071, 8'h71, 1'b1);
    wait_out(1, 30, "t7_out1");
    auto_assign = 1'b0;
    base = req_cnt;
    push(8'h72, 16'h0072, 8'h72, 1'b1);
    b = 30;
    while (req_cnt == base && b > 0) begin
      tick(1);
      b--;
    end
    chk("t7_issued", req_cnt - base, 1);
    push(8'h73, 16'h0073, 8'h73, 1'b1);
    tick(3);
    chk("t7_pre_qcount", {29'h0, queue_count}, 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("t7_async");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    base  = req_cnt;
    tick(10);
    chk("t7_no_req", req_cnt - base, 0);
    chk_reset_vals("t7_after");
    ubase = unk_cnt;
    done(8'h71);
    tick(2);
    chk("t7_table_cleared", unk_cnt - ubase, 1);
    chk("t7_out0", {28'h0, outstanding_cnt}, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
